multiplier_tiled_dsp: RTL and testbench
=======================================

MULTIPLIER_TILED_DSP -- requirements
Module: multiplier_tiled_dsp

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width in bits.
REQ-002 SHALL have parameter TILE, default 32, DSP row width; NT = WIDTH/TILE; WIDTH % TILE == 0 and TILE <= WIDTH are elaboration-time assertions.
REQ-003 Port clk: input, 1, single clock; all state updates on its rising edge.
REQ-004 Port reset: input, 1, asynchronous active-low reset; asserted when 0.
REQ-005 Port valid: input, 1, request present.
REQ-006 Port ready: output, 1, block can accept a request this cycle.
REQ-007 Port op: input, mul_op_t, operation select (MUL, MULH, MULHSU, MULHU, MULW).
REQ-008 Port a, b: input, WIDTH each, operands.
REQ-009 Port flush: input, 1, abort any in-flight operation.
REQ-010 Port done: output, 1, one-cycle result-valid pulse.
REQ-011 Port c: output, WIDTH, result; held stable from done until the next accept.

Function
REQ-012 States SHALL be IDLE, CALC, FIX and DONE; ready = 1 in IDLE and DONE, 0 in CALC and FIX.
REQ-013 Accept = valid && ready && !flush; on accept, op is registered along with |a|, |b| (magnitude per op signedness) and result sign = sa XOR sb, and state goes to CALC with row counter 0.
REQ-014 Signedness: MUL a,b signed; MULH a,b signed; MULHSU a signed, b unsigned; MULHU both unsigned; MULW uses a[WIDTH/2-1:0] and b[WIDTH/2-1:0] as unsigned.
REQ-015 Magnitude of the most negative value (e.g. 0x8000...0) SHALL be 2^(WIDTH-1), which is representable unsigned with no overflow.
REQ-016 Each CALC cycle i (0..NT-1) SHALL add |a| * |b|[i*TILE +: TILE], shifted left by i*TILE, into a 2*WIDTH-bit accumulator cleared on accept.
REQ-017 After row NT-1, state goes to FIX; FIX negates the 2*WIDTH accumulator (two's complement) if sign = 1, then selects the result into c and moves to DONE.
REQ-018 Result select: MUL = low WIDTH; MULH/MULHSU/MULHU = high WIDTH; MULW = low WIDTH/2 sign-extended to WIDTH.
REQ-019 done SHALL be 1 exactly in the DONE cycle; accept in cycle t gives done in cycle t+NT+2.
REQ-020 DONE -> CALC on accept (back-to-back issue, no bubble); otherwise DONE -> IDLE.
REQ-021 valid while ready = 0 SHALL be ignored; the upstream stage holds the request until ready.
REQ-022 flush = 1 SHALL force IDLE on the next edge from any state, suppress done, and leave c unchanged; flush with valid in the same cycle means no accept.
REQ-023 Operand ports SHALL be sampled only on accept; later changes to a, b or op SHALL NOT affect the in-flight result.

Reset
REQ-024 reset = 0 SHALL asynchronously force state IDLE, row counter 0, accumulator 0, c = 0, done = 0; ready = 1 once released.
REQ-025 Reset asserted mid-operation SHALL discard the operation; no done is ever produced for it.

Structure
REQ-026 mul_op_t (enum: MUL, MULH, MULHSU, MULHU, MULW) SHALL live in the shared common package; WIDTH/TILE defaults SHALL be localparams there.
REQ-027 Sub-module mul_tile_row SHALL implement the purely combinational WIDTH x TILE unsigned product, instantiated once and reused across CALC cycles, so it maps onto DSP slices.
REQ-028 All registers in the block SHALL use the asynchronous active-low reset; no latches.

Verification
REQ-029 Use WIDTH=64, TILE=32. op=MUL, a=3, b=0xFFFFFFFFFFFFFFFF (-1) -> c=0xFFFFFFFFFFFFFFFD, done in cycle t+4.
REQ-030 op=MULH, a=b=0x8000000000000000 -> c=0x4000000000000000; op=MULHU, same operands -> c=0x4000000000000000; op=MULHSU, a=-1, b=2 -> c=0xFFFFFFFFFFFFFFFF.
REQ-031 op=MULW, a=0x00000000_7FFFFFFF, b=2 -> c=0xFFFFFFFFFFFFFFFE.
REQ-032 Two requests issued back-to-back (second accepted in the first one's DONE cycle) -> done pulses 4 cycles apart, both results correct, valid during CALC/FIX ignored.
REQ-033 flush in cycle t+2 of an operation -> no done, c keeps its previous value, ready=1 in cycle t+3; new request then completes normally.
REQ-034 reset pulled low mid-CALC -> immediate IDLE, c=0, done=0; repeat with TILE=16 (NT=4): random signed/unsigned vectors match the reference model, done at t+6.

Source files
------------

// File: rtl/multiplier_tiled_dsp_pkg.sv
// Shared types and defaults for the tiled DSP multiplier.
package multiplier_tiled_dsp_pkg;

  localparam int unsigned MulWidthDefault = 64;
  localparam int unsigned MulTileDefault  = 32;

  typedef enum logic [2:0] {
    MUL,
    MULH,
    MULHSU,
    MULHU,
    MULW
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } mul_state_e;

  // Operand a is taken as two's complement for these ops.
  function automatic logic op_a_signed(mul_op_t op);
    return (op == MUL) || (op == MULH) || (op == MULHSU);
  endfunction

  // Operand b is taken as two's complement for these ops.
  function automatic logic op_b_signed(mul_op_t op);
    return (op == MUL) || (op == MULH);
  endfunction

endpackage

// File: rtl/mul_tile_row.sv
// Combinational WIDTH x TILE unsigned product; one DSP row reused every CALC cycle.
module mul_tile_row #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned TILE  = 32
) (
  input  logic [WIDTH-1:0]      a,
  input  logic [TILE-1:0]       b,
  output logic [WIDTH+TILE-1:0] p
);

  // Full-width unsigned product of the magnitude and one tile of the multiplier.
  always_comb begin
    p = (WIDTH+TILE)'(a) * (WIDTH+TILE)'(b);
  end

endmodule

// File: rtl/multiplier_tiled_dsp.sv
// Sequential multiplier: one TILE-wide row of the product per CALC cycle, sign fix-up
// in FIX, result presented with a one-cycle done pulse in DONE.
module multiplier_tiled_dsp
  import multiplier_tiled_dsp_pkg::*;
#(
  parameter int unsigned WIDTH = MulWidthDefault,
  parameter int unsigned TILE  = MulTileDefault
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  output logic             ready,
  input  mul_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             done,
  output logic [WIDTH-1:0] c
);

  localparam int unsigned NT    = WIDTH / TILE;
  localparam int unsigned CntW  = (NT > 1) ? $clog2(NT) : 1;
  localparam int unsigned AccW  = 2 * WIDTH;
  localparam int unsigned HalfW = WIDTH / 2;

  if (((WIDTH % TILE) != 0) || (TILE > WIDTH)) begin : gen_param_check
    $error("multiplier_tiled_dsp: TILE must divide WIDTH and not exceed it");
  end

  mul_state_e          state_q;
  mul_op_t             op_q;
  logic [CntW-1:0]     row_q;
  logic [AccW-1:0]     acc_q;
  logic [WIDTH-1:0]    mag_a_q, mag_b_q;
  logic                neg_q;
  logic [WIDTH-1:0]    c_q;
  logic                done_q;
  logic                ready_q;

  logic                accept;
  logic [WIDTH-1:0]    a_sel, b_sel;
  logic                sa, sb;
  logic [WIDTH-1:0]    mag_a, mag_b;
  logic [31:0]         shamt;
  logic [WIDTH-1:0]    b_shift;
  logic [TILE-1:0]     b_tile;
  logic [WIDTH+TILE-1:0] tile_prod;
  logic [AccW-1:0]     partial;
  logic [AccW-1:0]     acc_sum;
  logic [AccW-1:0]     acc_fix;
  logic [WIDTH-1:0]    res;

  assign accept = valid && ready_q && !flush;
  assign ready  = ready_q;
  assign done   = done_q;
  assign c      = c_q;

  // Operand selection and magnitude; the most negative value maps to 2^(WIDTH-1).
  always_comb begin
    a_sel = a;
    b_sel = b;
    sa    = op_a_signed(op) && a[WIDTH-1];
    sb    = op_b_signed(op) && b[WIDTH-1];
    if (op == MULW) begin
      a_sel            = '0;
      b_sel            = '0;
      a_sel[HalfW-1:0] = a[HalfW-1:0];
      b_sel[HalfW-1:0] = b[HalfW-1:0];
      sa               = 1'b0;
      sb               = 1'b0;
    end
    mag_a = sa ? -a_sel : a_sel;
    mag_b = sb ? -b_sel : b_sel;
  end

  // Pick the current multiplier tile and align its partial product.
  always_comb begin
    shamt   = 32'(row_q) * TILE;
    b_shift = mag_b_q >> shamt;
    b_tile  = b_shift[TILE-1:0];
    partial = '0;
    partial[WIDTH+TILE-1:0] = tile_prod;
    partial = partial << shamt;
    acc_sum = acc_q + partial;
  end

  mul_tile_row #(
    .WIDTH(WIDTH),
    .TILE (TILE)
  ) u_tile_row (
    .a(mag_a_q),
    .b(b_tile),
    .p(tile_prod)
  );

  // Sign fix-up and result selection from the finished accumulator.
  always_comb begin
    acc_fix = neg_q ? -acc_q : acc_q;
    res     = '0;
    unique case (op_q)
      MUL:                 res = acc_fix[WIDTH-1:0];
      MULH, MULHSU, MULHU: res = acc_fix[AccW-1:WIDTH];
      MULW:                res = {{(WIDTH-HalfW){acc_fix[HalfW-1]}}, acc_fix[HalfW-1:0]};
      default:             res = acc_fix[WIDTH-1:0];
    endcase
  end

  // Control FSM with registered ready/done; flush overrides everything but reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= MUL;
      row_q   <= '0;
      acc_q   <= '0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      neg_q   <= 1'b0;
      c_q     <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else if (flush) begin
      state_q <= IDLE;
      row_q   <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (accept) begin
            op_q    <= op;
            mag_a_q <= mag_a;
            mag_b_q <= mag_b;
            neg_q   <= sa ^ sb;
            acc_q   <= '0;
            row_q   <= '0;
            state_q <= CALC;
            ready_q <= 1'b0;
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        CALC: begin
          acc_q <= acc_sum;
          if (row_q == CntW'(NT - 1)) begin
            row_q   <= '0;
            state_q <= FIX;
          end else begin
            row_q <= row_q + CntW'(1);
          end
        end
        FIX: begin
          c_q     <= res;
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state_q <= DONE;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_tiled_dsp.sv
// Self-checking bench: two instances (TILE=32 and TILE=16) share stimulus and are
// compared against a plain signed-arithmetic reference model.
module tb_multiplier_tiled_dsp;
  import multiplier_tiled_dsp_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic        flush;
  mul_op_t     op;
  logic [63:0] a, b;
  logic        ready32, done32, ready16, done16;
  logic [63:0] c32, c16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multiplier_tiled_dsp #(.WIDTH(64), .TILE(32)) dut32 (
    .clk  (clk),
    .reset(reset),
    .valid(valid),
    .ready(ready32),
    .op   (op),
    .a    (a),
    .b    (b),
    .flush(flush),
    .done (done32),
    .c    (c32)
  );

  multiplier_tiled_dsp #(.WIDTH(64), .TILE(16)) dut16 (
    .clk  (clk),
    .reset(reset),
    .valid(valid),
    .ready(ready16),
    .op   (op),
    .a    (a),
    .b    (b),
    .flush(flush),
    .done (done16),
    .c    (c16)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact product of the operands as the op interprets them.
  function automatic logic [63:0] ref_mul(mul_op_t o, logic [63:0] x, logic [63:0] y);
    logic signed [129:0] xs, ys, p;
    case (o)
      MUL, MULH: begin
        xs = {{66{x[63]}}, x};
        ys = {{66{y[63]}}, y};
      end
      MULHSU: begin
        xs = {{66{x[63]}}, x};
        ys = {66'b0, y};
      end
      MULHU: begin
        xs = {66'b0, x};
        ys = {66'b0, y};
      end
      default: begin
        xs = {98'b0, x[31:0]};
        ys = {98'b0, y[31:0]};
      end
    endcase
    p = xs * ys;
    case (o)
      MUL:     return p[63:0];
      MULW:    return {{32{p[31]}}, p[31:0]};
      default: return p[127:64];
    endcase
  endfunction

  function automatic logic [63:0] rand_operand();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0:       v = 64'h8000_0000_0000_0000;
      1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
      2:       v = 64'h7FFF_FFFF_FFFF_FFFF;
      3:       v = {32'h0, $urandom()};
      default: v = {$urandom(), $urandom()};
    endcase
    return v;
  endfunction

  // Issue one request, scramble the ports after accept, check both instances.
  task automatic run_op(input mul_op_t o, input logic [63:0] x, input logic [63:0] y,
                        input logic [63:0] exp, input string tag);
    int lat32, lat16, n32, n16;
    logic [63:0] r32, r16;
    lat32 = -1; lat16 = -1; n32 = 0; n16 = 0; r32 = '0; r16 = '0;
    op = o; a = x; b = y; valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 1) begin
        valid = 1'b0;
        a     = {$urandom(), $urandom()};
        b     = {$urandom(), $urandom()};
        op    = mul_op_t'($urandom_range(0, 4));
      end
      if (done32) begin
        n32++;
        if (lat32 < 0) begin lat32 = k; r32 = c32; end
      end
      if (done16) begin
        n16++;
        if (lat16 < 0) begin lat16 = k; r16 = c16; end
      end
    end
    check({tag, "_lat32"}, lat32, 4);
    check({tag, "_lat16"}, lat16, 6);
    check({tag, "_pulses32"}, n32, 1);
    check({tag, "_pulses16"}, n16, 1);
    check({tag, "_c32"}, r32, exp);
    check({tag, "_c16"}, r16, exp);
    check({tag, "_hold32"}, c32, exp);
  endtask

  initial begin
    int nd;
    int nd16;
    mul_op_t ro;
    logic [63:0] ra, rb;

    reset = 1'b0; valid = 1'b0; flush = 1'b0; op = MUL; a = '0; b = '0;
    step(); step();
    check("rst_c32", c32, 0);
    check("rst_done32", done32, 0);
    check("rst_c16", c16, 0);
    check("rst_done16", done16, 0);
    reset = 1'b1;
    step();
    check("rst_ready32", ready32, 1);
    check("rst_ready16", ready16, 1);

    run_op(MUL, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD, "mul_3xm1");
    run_op(MULH, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
           64'h4000_0000_0000_0000, "mulh_min");
    run_op(MULHU, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
           64'h4000_0000_0000_0000, "mulhu_min");
    run_op(MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, "mulhsu");
    run_op(MULW, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, "mulw");

    // Back-to-back on the TILE=32 instance; second request held through CALC/FIX.
    op = MUL; a = 64'd7; b = 64'd9; valid = 1'b1; nd = 0;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 1) begin
        op = MULHU; a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF;
      end
      if (k == 2) check("b2b_busy_ready", ready32, 0);
      if (k == 4) begin
        check("b2b_done1", done32, 1);
        check("b2b_c1", c32, 64'd63);
      end
      if (k == 5) valid = 1'b0;
      if (k == 8) begin
        check("b2b_done2", done32, 1);
        check("b2b_c2", c32, 64'hFFFF_FFFF_FFFF_FFFE);
      end
      if (done32) nd++;
    end
    check("b2b_pulses", nd, 2);
    for (int k = 0; k < 6; k++) step();

    // Flush in cycle t+2: no done, c held, ready back next cycle.
    run_op(MUL, 64'd5, 64'd6, 64'd30, "pre_flush");
    op = MULHU; a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()};
    valid = 1'b1; nd = 0; nd16 = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 1) valid = 1'b0;
      if (k == 2) flush = 1'b1;
      if (k == 3) begin
        flush = 1'b0;
        check("flush_ready32", ready32, 1);
      end
      if (done32) nd++;
      if (done16) nd16++;
    end
    check("flush_no_done32", nd, 0);
    check("flush_no_done16", nd16, 0);
    check("flush_c32_kept", c32, 64'd30);
    check("flush_c16_kept", c16, 64'd30);

    // Flush together with valid must not accept.
    op = MUL; a = 64'd11; b = 64'd13; valid = 1'b1; flush = 1'b1;
    step();
    valid = 1'b0; flush = 1'b0; nd = 0;
    check("flushvalid_ready", ready32, 1);
    for (int k = 0; k < 8; k++) begin
      step();
      if (done32 || done16) nd++;
    end
    check("flushvalid_no_done", nd, 0);
    run_op(MULH, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0003,
           64'hFFFF_FFFF_FFFF_FFFF, "post_flush");

    // Asynchronous reset during CALC discards the operation.
    op = MUL; a = 64'd1234; b = 64'd5678; valid = 1'b1;
    step();
    valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("rstmid_c32", c32, 0);
    check("rstmid_done32", done32, 0);
    check("rstmid_c16", c16, 0);
    step();
    reset = 1'b1;
    nd = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (done32 || done16) nd++;
    end
    check("rstmid_no_done", nd, 0);
    check("rstmid_ready32", ready32, 1);
    check("rstmid_ready16", ready16, 1);

    // Random vectors against the reference model.
    for (int i = 0; i < 40; i++) begin
      ro = mul_op_t'($urandom_range(0, 4));
      ra = rand_operand();
      rb = rand_operand();
      run_op(ro, ra, rb, ref_mul(ro, ra, rb), $sformatf("rnd%0d_%s", i, ro.name()));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
